// File: rtl/window_pkg.sv
// ---------------------------------------------------------------------------
// window_pkg
//  Shared definitions for the streaming windower.
//  Contents:
//    DEF_DATA_W / DEF_COEF_W   default sample and coefficient widths
//    sample_t / coef_t         sample and coefficient types at the default widths
//    coef_one()                1.0 in Q1.(coef_w-1) for any coefficient width
//    ONE                       1.0 at the default coefficient width
//    round_sat()               product -> rounded, saturated DATA_W-range value
// ---------------------------------------------------------------------------
package window_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_COEF_W = 8;

   typedef logic signed [DEF_DATA_W-1:0] sample_t;
   typedef logic        [DEF_COEF_W-1:0] coef_t;

   // 1.0 in unsigned Q1.(coef_w-1): only the top coefficient bit set.
   function automatic logic [63:0] coef_one(input int coef_w);
      return 64'd1 << (coef_w - 1);
   endfunction

   localparam coef_t ONE = coef_t'(coef_one(DEF_COEF_W));

   // Round half up, drop the coefficient fraction bits, then clamp to the
   // signed data_w range. The result is 64 bits wide so it works for any
   // width pair; callers size-cast it down to data_w.
   function automatic logic signed [63:0] round_sat(input logic signed [63:0] p,
                                                    input int                 coef_w,
                                                    input int                 data_w);
      logic signed [63:0] r;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      r  = (p + (64'sd1 <<< (coef_w - 2))) >>> (coef_w - 1);
      hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (data_w - 1));
      if (r > hi) begin
         return hi;
      end
      if (r < lo) begin
         return lo;
      end
      return r;
   endfunction

endpackage

// File: rtl/window_coef_bank.sv
// ---------------------------------------------------------------------------
// window_coef_bank
//  BANKS x N coefficient register file. Every word resets to 1.0, so an
//  unconfigured bank behaves as a rectangular window.
//  Ports:
//    clk, rst              clock, asynchronous active-high reset
//    we, wr_bank, wr_addr, synchronous write port; writes aimed outside the
//    wr_data               BANKS x N array are dropped
//    rd_bank, rd_addr      combinational read address
//    rd_data               coefficient at (rd_bank, rd_addr); an out-of-range
//                          bank reads as 1.0
//  Because the read is combinational from the registers, a read and a write
//  to the same word in one cycle return the value from before that edge.
// ---------------------------------------------------------------------------
module window_coef_bank
   import window_pkg::*;
#(
   parameter int N      = 8,
   parameter int COEF_W = 8,
   parameter int BANKS  = 2,
   parameter int IDX_W  = 3,
   parameter int BANK_W = 1
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [BANK_W-1:0] wr_bank,
   input  logic [IDX_W-1:0]  wr_addr,
   input  logic [COEF_W-1:0] wr_data,
   input  logic [BANK_W-1:0] rd_bank,
   input  logic [IDX_W-1:0]  rd_addr,
   output logic [COEF_W-1:0] rd_data
);

   localparam logic [COEF_W-1:0] COEF_ONE = COEF_W'(coef_one(COEF_W));

   logic [COEF_W-1:0] mem_reg [BANKS][N];
   logic [COEF_W-1:0] row_word [BANKS];
   logic              wr_in_range;
   logic              rd_in_range;

   // Non-power-of-two BANKS or N leave unused address codes; they are filtered.
   assign wr_in_range = (32'(wr_bank) < BANKS) && (32'(wr_addr) < N);
   assign rd_in_range = (32'(rd_bank) < BANKS) && (32'(rd_addr) < N);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < BANKS; b++) begin
            for (int a = 0; a < N; a++) begin
               mem_reg[b][a] <= COEF_ONE;
            end
         end
      end else if (we && wr_in_range) begin
         mem_reg[wr_bank][wr_addr] <= wr_data;
      end
   end

   // Select the addressed word in every bank first, then pick the bank.
   for (genvar gi = 0; gi < BANKS; gi++) begin : g_row
      assign row_word[gi] = mem_reg[gi][rd_addr];
   end

   assign rd_data = rd_in_range ? row_word[rd_bank] : COEF_ONE;

endmodule

// File: rtl/window_stream.sv
// ---------------------------------------------------------------------------
// window_stream
//  Streaming windower: each accepted signed sample is multiplied by the
//  coefficient for its position in the frame, rounded half up, saturated and
//  sent downstream with its frame index and a last-sample flag.
//  Ports:
//    clk, rst                          clock, asynchronous active-high reset
//    cfg_we/cfg_bank/cfg_addr/cfg_data coefficient write port
//    bank_sel, bypass                  window choice, captured with index 0
//    in_valid/in_data/in_ready         input stream
//    out_valid/out_data/out_index/
//    out_last/out_ready                output stream
//  Pipeline: S1 holds sample, index, coefficient and bypass; S2 holds the
//  finished sample. Two cycles accept-to-valid, one sample per cycle.
// ---------------------------------------------------------------------------
module window_stream
   import window_pkg::*;
#(
   parameter  int N      = 8,
   parameter  int DATA_W = 8,
   parameter  int COEF_W = 8,
   parameter  int BANKS  = 2,
   localparam int IDX_W  = $clog2(N),
   localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cfg_we,
   input  logic [BANK_W-1:0]        cfg_bank,
   input  logic [IDX_W-1:0]         cfg_addr,
   input  logic [COEF_W-1:0]        cfg_data,
   input  logic [BANK_W-1:0]        bank_sel,
   input  logic                     bypass,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] in_data,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic signed [DATA_W-1:0] out_data,
   output logic [IDX_W-1:0]         out_index,
   output logic                     out_last,
   input  logic                     out_ready
);

   localparam int PROD_W = DATA_W + COEF_W + 1;

   // frame position and the window choice captured at its start
   logic [IDX_W-1:0]         idx_reg;
   logic [IDX_W-1:0]         idx_next;
   logic [BANK_W-1:0]        bank_reg;
   logic                     bypass_reg;

   // stage 1
   logic                     s1_valid_reg;
   logic signed [DATA_W-1:0] s1_data_reg;
   logic [COEF_W-1:0]        s1_coef_reg;
   logic [IDX_W-1:0]         s1_index_reg;
   logic                     s1_bypass_reg;

   // stage 2
   logic                     s2_valid_reg;
   logic signed [DATA_W-1:0] s2_data_reg;
   logic [IDX_W-1:0]         s2_index_reg;
   logic                     s2_last_reg;

   logic                     s2_load;
   logic                     s1_load;
   logic                     accept;
   logic                     frame_start;
   logic [BANK_W-1:0]        eff_bank;
   logic                     eff_bypass;
   logic [COEF_W-1:0]        coef_rd;
   logic signed [PROD_W-1:0] prod;
   logic signed [DATA_W-1:0] windowed;

   // Handshake: a stage loads when it is empty or its contents move on.
   assign s2_load  = !s2_valid_reg || out_ready;
   assign s1_load  = !s1_valid_reg || s2_load;
   assign in_ready = s1_load;
   assign accept   = in_valid && s1_load;

   // The index-0 sample must already use the choice it is about to latch,
   // so at frame start the live inputs bypass the frame registers.
   assign frame_start = (idx_reg == '0);
   assign eff_bank    = frame_start ? bank_sel : bank_reg;
   assign eff_bypass  = frame_start ? bypass   : bypass_reg;
   assign idx_next    = (idx_reg == IDX_W'(N - 1)) ? '0 : idx_reg + IDX_W'(1);

   window_coef_bank #(
      .N      (N),
      .COEF_W (COEF_W),
      .BANKS  (BANKS),
      .IDX_W  (IDX_W),
      .BANK_W (BANK_W)
   ) u_coef (
      .clk     (clk),
      .rst     (rst),
      .we      (cfg_we),
      .wr_bank (cfg_bank),
      .wr_addr (cfg_addr),
      .wr_data (cfg_data),
      .rd_bank (eff_bank),
      .rd_addr (idx_reg),
      .rd_data (coef_rd)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_reg    <= '0;
         bank_reg   <= '0;
         bypass_reg <= 1'b0;
      end else if (accept) begin
         idx_reg <= idx_next;
         if (frame_start) begin
            bank_reg   <= bank_sel;
            bypass_reg <= bypass;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_reg  <= 1'b0;
         s1_data_reg   <= '0;
         s1_coef_reg   <= '0;
         s1_index_reg  <= '0;
         s1_bypass_reg <= 1'b0;
      end else if (s1_load) begin
         s1_valid_reg <= accept;
         if (accept) begin
            s1_data_reg   <= in_data;
            s1_coef_reg   <= coef_rd;
            s1_index_reg  <= idx_reg;
            s1_bypass_reg <= eff_bypass;
         end
      end
   end

   // Coefficient is unsigned: zero-extend it so the product stays signed
   // and exact in PROD_W bits.
   assign prod = $signed({{(COEF_W + 1){s1_data_reg[DATA_W-1]}}, s1_data_reg})
               * $signed({{(DATA_W + 1){1'b0}}, s1_coef_reg});

   always_comb begin
      windowed = s1_data_reg;
      if (!s1_bypass_reg) begin
         windowed = DATA_W'(round_sat(64'(prod), COEF_W, DATA_W));
      end
   end

   // S2 contents change only on a load, so a stalled output holds steady.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid_reg <= 1'b0;
         s2_data_reg  <= '0;
         s2_index_reg <= '0;
         s2_last_reg  <= 1'b0;
      end else if (s2_load) begin
         s2_valid_reg <= s1_valid_reg;
         if (s1_valid_reg) begin
            s2_data_reg  <= windowed;
            s2_index_reg <= s1_index_reg;
            s2_last_reg  <= (s1_index_reg == IDX_W'(N - 1));
         end
      end
   end

   assign out_valid = s2_valid_reg;
   assign out_data  = s2_data_reg;
   assign out_index = s2_index_reg;
   assign out_last  = s2_last_reg;

endmodule

// File: tb/tb_window_stream.sv
// ---------------------------------------------------------------------------
// tb_window_stream
//  Self-checking bench for window_stream (N=8, DATA_W=8, COEF_W=8, BANKS=2).
//  A reference model predicts every output transfer from the accepted inputs
//  using plain integer arithmetic; fixed vectors and hand-written sequences
//  cover the named corner cases.
// ---------------------------------------------------------------------------
module tb_window_stream;

   localparam int N     = 8;
   localparam int DW    = 8;
   localparam int CW    = 8;
   localparam int BANKS = 2;
   localparam int IW    = 3;
   localparam int BW    = 1;
   localparam int SCALE = 128;   // 1.0
   localparam int HALF  = 64;    // rounding offset
   localparam int SMAX  = 127;
   localparam int SMIN  = -128;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 cfg_we;
   logic [BW-1:0]        cfg_bank;
   logic [IW-1:0]        cfg_addr;
   logic [CW-1:0]        cfg_data;
   logic [BW-1:0]        bank_sel;
   logic                 bypass;
   logic                 in_valid;
   logic signed [DW-1:0] in_data;
   logic                 in_ready;
   logic                 out_valid;
   logic signed [DW-1:0] out_data;
   logic [IW-1:0]        out_index;
   logic                 out_last;
   logic                 out_ready;

   window_stream #(
      .N      (N),
      .DATA_W (DW),
      .COEF_W (CW),
      .BANKS  (BANKS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_we    (cfg_we),
      .cfg_bank  (cfg_bank),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data),
      .bank_sel  (bank_sel),
      .bypass    (bypass),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_index (out_index),
      .out_last  (out_last),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int data;
      int index;
      int last;
   } out_t;

   typedef struct {
      int din;
      int coef;
      int bank;
      int byp;
      int expv;
   } vec_t;

   out_t exp_q[$];
   out_t rx_q[$];
   int   m_coef [BANKS][N];
   int   m_idx;
   int   m_bank;
   int   m_byp;
   int   n_cmp = 0;
   int   n_fail = 0;
   int   first_acc = -1;
   int   first_val = -1;
   int   acc_cnt = 0;
   bit   took;
   bit   rand_ready = 1'b0;
   vec_t vecs [11];

   task automatic chk(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   // Window arithmetic from its definition: floor((d*c + 1/2 LSB) / 1.0), clamped.
   function automatic int ref_win(input int d, input int c);
      int x;
      int r;
      x = d * c + HALF;
      if (x >= 0) r = x / SCALE;
      else        r = -((-x + SCALE - 1) / SCALE);
      if (r > SMAX) r = SMAX;
      if (r < SMIN) r = SMIN;
      return r;
   endfunction

   task automatic model_reset();
      exp_q.delete();
      rx_q.delete();
      m_idx  = 0;
      m_bank = 0;
      m_byp  = 0;
      for (int b = 0; b < BANKS; b++)
         for (int a = 0; a < N; a++)
            m_coef[b][a] = SCALE;
   endtask

   task automatic model_accept(input int d);
      out_t e;
      if (m_idx == 0) begin
         m_bank = int'(bank_sel);
         m_byp  = int'(bypass);
      end
      e.data  = (m_byp != 0) ? d : ref_win(d, m_coef[m_bank][m_idx]);
      e.index = m_idx;
      e.last  = (m_idx == N - 1) ? 1 : 0;
      exp_q.push_back(e);
      m_idx = (m_idx + 1) % N;
      acc_cnt++;
      if (first_acc < 0) first_acc = cyc;
   endtask

   // One clock: observe both handshakes at the falling edge, then let the
   // rising edge happen and return 1 time unit after it.
   task automatic step();
      out_t g;
      out_t e;
      @(negedge clk);
      took = 1'b0;
      if (!rst) begin
         if (out_valid && first_val < 0) first_val = cyc;
         if (out_valid && out_ready) begin
            g.data  = int'(out_data);
            g.index = int'(out_index);
            g.last  = int'(out_last);
            $display("OUT index=%0d data=%0d last=%0d", g.index, g.data, g.last);
            rx_q.push_back(g);
            if (exp_q.size() == 0) begin
               chk("unexpected_output", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("model_data", g.data, e.data);
               chk("model_index", g.index, e.index);
               chk("model_last", g.last, e.last);
            end
         end
         if (in_valid && in_ready) begin
            model_accept(int'(in_data));
            took = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic send(input int d);
      in_valid = 1'b1;
      in_data  = DW'(d);
      for (int t = 0; t < 100; t++) begin
         step();
         if (took) return;
      end
      chk("send_timeout", 0, 1);
   endtask

   task automatic drain();
      in_valid = 1'b0;
      for (int t = 0; t < 200 && exp_q.size() > 0; t++) step();
      chk("drain_left", exp_q.size(), 0);
   endtask

   task automatic cfg_write(input int b, input int a, input int v);
      cfg_we   = 1'b1;
      cfg_bank = BW'(b);
      cfg_addr = IW'(a);
      cfg_data = CW'(v);
      step();
      cfg_we = 1'b0;
      m_coef[b][a] = v;
   endtask

   task automatic fill_bank(input int b, input int v);
      for (int a = 0; a < N; a++) cfg_write(b, a, v);
   endtask

   // Expect rx_q to hold n outputs: the first k equal va, the rest vb.
   task automatic check_split(input string name, input int n, input int k,
                              input int va, input int vb);
      chk({name, "_count"}, rx_q.size(), n);
      for (int i = 0; i < n && i < rx_q.size(); i++)
         chk($sformatf("%s_%0d", name, i), rx_q[i].data, (i < k) ? va : vb);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int sd;
      int si;
      int a0;
      int nxt;

      vecs[0]  = '{100,  69, 1, 0,   54};
      vecs[1]  = '{-100, 69, 1, 0,  -54};
      vecs[2]  = '{127, 255, 1, 0,  127};
      vecs[3]  = '{-128, 255, 1, 0, -128};
      vecs[4]  = '{-1,  255, 1, 0,   -2};
      vecs[5]  = '{37,   69, 1, 1,   37};
      vecs[6]  = '{-77, 128, 0, 0,  -77};
      vecs[7]  = '{3,   200, 0, 0,    5};
      vecs[8]  = '{-3,  200, 0, 0,   -5};
      vecs[9]  = '{1,    64, 0, 0,    1};
      vecs[10] = '{-1,   64, 0, 0,    0};

      rst = 1'b1; cfg_we = 1'b0; cfg_bank = '0; cfg_addr = '0; cfg_data = '0;
      bank_sel = '0; bypass = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_out_valid", int'(out_valid), 0);
      chk("reset_out_data", int'(out_data), 0);
      chk("reset_out_index", int'(out_index), 0);
      chk("reset_out_last", int'(out_last), 0);
      chk("reset_in_ready", int'(in_ready), 1);
      rst = 1'b0;

      // Default coefficients: unity gain, latency and last marking.
      rx_q.delete();
      for (int i = 0; i < N; i++) send(1);
      drain();
      check_split("unity", N, N, 1, 1);
      for (int i = 0; i < N && i < rx_q.size(); i++)
         chk($sformatf("unity_last_%0d", i), rx_q[i].last, (i == N - 1) ? 1 : 0);
      chk("first_latency", first_val - first_acc, 2);

      // Fixed vectors, one full frame each.
      for (int v = 0; v < 11; v++) begin
         if (vecs[v].byp == 0) fill_bank(vecs[v].bank, vecs[v].coef);
         bank_sel = BW'(vecs[v].bank);
         bypass   = (vecs[v].byp != 0);
         rx_q.delete();
         for (int i = 0; i < N; i++) send(vecs[v].din);
         drain();
         check_split($sformatf("vec%0d", v), N, N, vecs[v].expv, vecs[v].expv);
         $display("VEC %0d din=%0d coef=%0d bank=%0d bypass=%0d want=%0d",
                  v, vecs[v].din, vecs[v].coef, vecs[v].bank, vecs[v].byp, vecs[v].expv);
      end

      // Five-cycle output stall mid-frame, two frames of ascending samples.
      bank_sel = '0; bypass = 1'b1; out_ready = 1'b1;
      rx_q.delete();
      for (int k = 0; k < 11; k++) send(10 + k);
      nxt = 11;
      in_data = DW'(10 + nxt);
      out_ready = 1'b0;
      sd = int'(out_data);
      si = int'(out_index);
      a0 = acc_cnt;
      for (int c = 0; c < 5; c++) begin
         step();
         if (took) begin
            nxt++;
            in_data = DW'(10 + nxt);
         end
         chk("stall_data_hold", int'(out_data), sd);
         chk("stall_index_hold", int'(out_index), si);
      end
      chk("stall_accepts_le2", int'((acc_cnt - a0) <= 2), 1);
      chk("stall_in_ready", int'(in_ready), 0);
      out_ready = 1'b1;
      while (nxt < 16) begin
         send(10 + nxt);
         nxt++;
      end
      drain();
      chk("stall_count", rx_q.size(), 16);
      for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
         chk($sformatf("stall_order_%0d", i), rx_q[i].data, 10 + i);
         chk($sformatf("stall_idx_%0d", i), rx_q[i].index, i % N);
      end

      // Mid-frame bank_sel change takes effect on the next frame only.
      fill_bank(0, 64);
      fill_bank(1, 255);
      bank_sel = '0; bypass = 1'b0;
      rx_q.delete();
      for (int i = 0; i < 2 * N; i++) begin
         if (i == 3) bank_sel = 1'b1;
         send(20);
      end
      drain();
      check_split("bank_toggle", 2 * N, N, 10, 40);

      // Mid-frame bypass change likewise.
      rx_q.delete();
      for (int i = 0; i < 2 * N; i++) begin
         if (i == 3) bypass = 1'b1;
         send(20);
      end
      drain();
      check_split("bypass_toggle", 2 * N, N, 40, 20);

      // Random coefficients, samples, window choices, gaps and backpressure.
      for (int b = 0; b < BANKS; b++)
         for (int a = 0; a < N; a++)
            cfg_write(b, a, int'($urandom_range(0, 255)));
      rand_ready = 1'b1;
      for (int i = 0; i < 25 * N; i++) begin
         if ($urandom_range(0, 4) == 0) begin
            in_valid = 1'b0;
            step();
         end
         bank_sel = BW'($urandom_range(0, 1));
         bypass   = ($urandom_range(0, 3) == 0);
         send(int'($urandom_range(0, 255)) - 128);
      end
      rand_ready = 1'b0;
      out_ready  = 1'b1;
      drain();

      // Reset while stalled with index 5 at the output.
      bank_sel = '0; bypass = 1'b0; out_ready = 1'b1;
      fill_bank(1, 200);
      for (int k = 0; k < 5; k++) send(k + 1);
      drain();
      out_ready = 1'b0;
      send(6);
      send(7);
      in_valid = 1'b0;
      chk("pre_reset_index", int'(out_index), 5);
      chk("pre_reset_valid", int'(out_valid), 1);
      rst = 1'b1;
      #1;
      chk("async_rst_out_valid", int'(out_valid), 0);
      chk("async_rst_out_data", int'(out_data), 0);
      chk("async_rst_out_index", int'(out_index), 0);
      chk("async_rst_out_last", int'(out_last), 0);
      chk("async_rst_in_ready", int'(in_ready), 1);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      bank_sel = 1'b1;
      out_ready = 1'b1;
      send(55);
      drain();
      chk("post_reset_count", rx_q.size(), 1);
      if (rx_q.size() > 0) begin
         chk("post_reset_data", rx_q[0].data, 55);
         chk("post_reset_index", rx_q[0].index, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
